// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down counter family.
package counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // A load value outside the count range is pinned to the top of the range.
    function automatic int clamp_load(input int value, input int modulus);
        return (value >= modulus) ? (modulus - 1) : value;
    endfunction

endpackage

// File: rtl/updown_next.sv
// Next-count and wrap-event logic for updown_counter; purely combinational.
module updown_next
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] counter,
    input  logic             up,
    input  logic             en,
    output logic [WIDTH-1:0] next,
    output logic             wrap_event
);

    localparam logic [WIDTH:0] TOP = (WIDTH+1)'(MODULUS - 1);

    logic [WIDTH:0] wide;
    logic [WIDTH:0] next_wide;

    assign wide = {1'b0, counter};

    // Bounds are detected by compare, so a modulus below 2^WIDTH wraps correctly.
    always_comb begin
        next_wide  = wide;
        wrap_event = 1'b0;
        if (en) begin
            if (up) begin
                if (wide == TOP) begin
                    if (SATURATE != MODE_SAT) begin
                        next_wide  = '0;
                        wrap_event = 1'b1;
                    end
                end else begin
                    next_wide = wide + 1'b1;
                end
            end else begin
                if (wide == '0) begin
                    if (SATURATE != MODE_SAT) begin
                        next_wide  = TOP;
                        wrap_event = 1'b1;
                    end
                end else begin
                    next_wide = wide - 1'b1;
                end
            end
        end
    end

    assign next = WIDTH'(next_wide);

endmodule

// File: rtl/updown_counter.sv
// Loadable up/down counter with modulus, wrap/saturate mode, terminal count and wrap pulse.
module updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter int RESET_VAL = 0,
    parameter int SATURATE  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] counter,
    output logic             tc,
    output logic             wrap
);

    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("updown_counter: WIDTH must be 2..16");
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("updown_counter: MODULUS must be 2..2^WIDTH");
    end
    if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset_val
        $error("updown_counter: RESET_VAL must be below MODULUS");
    end

    localparam logic [WIDTH-1:0] CNT_TOP   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] CNT_RESET = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] next;
    logic             wrap_event;
    logic [WIDTH-1:0] load_clamped;

    updown_next #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_next (
        .counter    (counter),
        .up         (up),
        .en         (en),
        .next       (next),
        .wrap_event (wrap_event)
    );

    assign load_clamped = WIDTH'(clamp_load(32'(load_value), MODULUS));

    always_ff @(posedge clk) begin
        if (reset) begin
            counter <= CNT_RESET;
            wrap    <= 1'b0;
        end else if (load) begin
            counter <= load_clamped;
            wrap    <= 1'b0;
        end else begin
            counter <= next;
            wrap    <= wrap_event;
        end
    end

    assign tc = up ? (counter == CNT_TOP) : (counter == '0);

endmodule

// File: tb/tb_updown_counter.sv
// Scoreboard bench: three counter configurations share stimulus, each checked against an arithmetic model.
module tb_updown_counter;

    localparam int NDUT = 3;
    localparam int MODS [NDUT] = '{16, 10, 10};
    localparam int SATS [NDUT] = '{0, 0, 1};
    localparam int RVS  [NDUT] = '{0, 0, 3};

    logic       clk;
    logic       reset;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_value;
    logic [3:0] cnt  [NDUT];
    logic       tc   [NDUT];
    logic       wrap [NDUT];

    typedef struct {
        int cnt;
        bit wrap;
        bit tc;
    } exp_t;

    exp_t exp_q [NDUT][$];
    int   model_cnt [NDUT];
    int   vectors;
    int   miscompares;

    updown_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0), .SATURATE(0)) dut_m16 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_value(load_value),
        .counter(cnt[0]), .tc(tc[0]), .wrap(wrap[0]));

    updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0), .SATURATE(0)) dut_m10 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_value(load_value),
        .counter(cnt[1]), .tc(tc[1]), .wrap(wrap[1]));

    updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(3), .SATURATE(1)) dut_m10s (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_value(load_value),
        .counter(cnt[2]), .tc(tc[2]), .wrap(wrap[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs and push what each counter must show after the edge.
    task automatic step(input bit r, input bit ld, input int lv, input bit e, input bit u);
        @(negedge clk);
        reset      = r;
        load       = ld;
        load_value = 4'(lv);
        en         = e;
        up         = u;
        for (int d = 0; d < NDUT; d++) begin
            exp_t x;
            int   m;
            m      = MODS[d];
            x.wrap = 1'b0;
            if (r) begin
                model_cnt[d] = RVS[d];
            end else if (ld) begin
                model_cnt[d] = (lv >= m) ? m - 1 : lv;
            end else if (e) begin
                if (u) begin
                    if (model_cnt[d] + 1 < m)   model_cnt[d] = model_cnt[d] + 1;
                    else if (SATS[d] == 0) begin
                        model_cnt[d] = (model_cnt[d] + 1) % m;
                        x.wrap       = 1'b1;
                    end
                end else begin
                    if (model_cnt[d] - 1 >= 0)  model_cnt[d] = model_cnt[d] - 1;
                    else if (SATS[d] == 0) begin
                        model_cnt[d] = (model_cnt[d] - 1 + m) % m;
                        x.wrap       = 1'b1;
                    end
                end
            end
            x.cnt = model_cnt[d];
            x.tc  = u ? (model_cnt[d] == m - 1) : (model_cnt[d] == 0);
            exp_q[d].push_back(x);
        end
    endtask

    always @(posedge clk) begin
        #1;
        for (int d = 0; d < NDUT; d++) begin
            if (exp_q[d].size() > 0) begin
                exp_t x;
                x = exp_q[d].pop_front();
                vectors++;
                if (int'(cnt[d]) != x.cnt || wrap[d] !== x.wrap || tc[d] !== x.tc) begin
                    miscompares++;
                    $display("FAIL dut%0d t=%0t: counter=%0d wrap=%b tc=%b, expected counter=%0d wrap=%b tc=%b",
                             d, $time, cnt[d], wrap[d], tc[d], x.cnt, x.wrap, x.tc);
                end
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        load        = 1'b0;
        load_value  = '0;
        en          = 1'b0;
        up          = 1'b0;
        for (int d = 0; d < NDUT; d++) model_cnt[d] = RVS[d];

        // down-count through the bottom bound
        step(1, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 1, 0);
        // up-count through the top bound
        step(1, 0, 0, 0, 1);
        repeat (11) step(0, 0, 0, 1, 1);
        // run into both bounds
        repeat (12) step(0, 0, 0, 1, 1);
        repeat (12) step(0, 0, 0, 1, 0);
        // clamped load, then load overriding en
        step(0, 1, 13, 1, 1);
        step(0, 1, 4, 1, 0);
        // reset beats load mid-count
        step(0, 1, 7, 0, 1);
        step(1, 1, 2, 1, 1);
        step(0, 0, 0, 0, 1);
        // direction flips with gated enable
        step(0, 1, 5, 0, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), 1'($urandom));
        end

        @(negedge clk);
        en   = 1'b0;
        load = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0) break;
            @(negedge clk);
        end
        for (int d = 0; d < NDUT; d++) begin
            if (exp_q[d].size() != 0) begin
                miscompares++;
                $display("FAIL drain dut%0d: %0d pending, expected 0", d, exp_q[d].size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
